// File: rtl/psum_deskew_buffer_pkg.sv
// Shared defaults and width helpers for the partial-sum deskew buffer.
package psum_deskew_buffer_pkg;

  localparam int SYSTOLIC_SIZE_DEF = 8;
  localparam int PSUM_WIDTH_DEF    = 24;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/psum_deskew_buffer_sync_fifo.sv
// First-word-fall-through queue of aligned rows; read data is the head entry.
module psum_deskew_buffer_sync_fifo
  import psum_deskew_buffer_pkg::*;
#(
  parameter int WIDTH = PSUM_WIDTH_DEF,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [WIDTH-1:0]        wr_data,
  output logic                    full,
  input  logic                    rd_en,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_wr_s;
  logic             do_rd_s;

  assign empty   = (count_r == CW'(0));
  assign full    = (count_r == CW'(DEPTH));
  assign count   = count_r;
  assign rd_data = mem_r[rd_ptr_r];
  assign do_rd_s = rd_en && !empty;
  assign do_wr_s = wr_en && (!full || do_rd_s);

  // Storage, wrapping pointers and exact occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_r[k] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_wr_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/psum_deskew_buffer.sv
// Re-aligns the skewed bottom-of-array partial sums into one row per cycle and
// queues completed rows for output_mem; test mode bypasses to the BIST port.
module psum_deskew_buffer
  import psum_deskew_buffer_pkg::*;
#(
  parameter int SYSTOLIC_SIZE = SYSTOLIC_SIZE_DEF,
  parameter int PSUM_WIDTH    = PSUM_WIDTH_DEF,
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                test_mode,
  input  logic [SYSTOLIC_SIZE*PSUM_WIDTH-1:0] psum_in_flat,
  input  logic                                psum_valid_in,
  output logic [SYSTOLIC_SIZE*PSUM_WIDTH-1:0] psum_test_out_flat,
  output logic [SYSTOLIC_SIZE*PSUM_WIDTH-1:0] psum_out_flat,
  output logic                                psum_out_valid,
  input  logic                                psum_out_ready,
  output logic [clog2(FIFO_DEPTH):0]          fifo_count,
  output logic                                overflow,
  output logic [CNT_WIDTH-1:0]                rows_written
);

  localparam int N = SYSTOLIC_SIZE;
  localparam int W = PSUM_WIDTH;

  logic [N*W-1:0]       aligned_s;
  logic                 tail_valid_s;
  logic                 wr_en_s;
  logic                 rd_s;
  logic                 wr_ok_s;
  logic                 drop_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic                 overflow_r;
  logic [CNT_WIDTH-1:0] rows_written_r;

  assign psum_test_out_flat = psum_in_flat;

  // Early columns wait longer so every column of a row lines up on one cycle.
  for (genvar j = 0; j < N; j++) begin : g_col
    localparam int DLY = N - 1 - j;
    if (DLY == 0) begin : g_direct
      assign aligned_s[j*W +: W] = psum_in_flat[j*W +: W];
    end else begin : g_delay
      logic [W-1:0] dly_r [DLY];
      // Free-running column delay line.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < DLY; k++) begin
            dly_r[k] <= '0;
          end
        end else begin
          dly_r[0] <= psum_in_flat[j*W +: W];
          for (int k = 1; k < DLY; k++) begin
            dly_r[k] <= dly_r[k-1];
          end
        end
      end
      assign aligned_s[j*W +: W] = dly_r[DLY-1];
    end
  end

  if (N > 1) begin : g_vpipe
    logic [N-2:0] vpipe_r;
    // Valid tracks column 0; flushed in test mode so partial rows never land.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vpipe_r <= '0;
      end else if (test_mode) begin
        vpipe_r <= '0;
      end else begin
        vpipe_r[0] <= psum_valid_in;
        for (int i = 1; i < N - 1; i++) begin
          vpipe_r[i] <= vpipe_r[i-1];
        end
      end
    end
    assign tail_valid_s = vpipe_r[N-2];
  end else begin : g_novpipe
    assign tail_valid_s = psum_valid_in;
  end

  assign wr_en_s        = tail_valid_s && !test_mode;
  assign psum_out_valid = !fifo_empty_s;
  assign rd_s           = psum_out_valid && psum_out_ready;
  assign wr_ok_s        = wr_en_s && (!fifo_full_s || rd_s);
  assign drop_s         = wr_en_s && fifo_full_s && !rd_s;

  psum_deskew_buffer_sync_fifo #(
    .WIDTH (N*W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_ok_s),
    .wr_data (aligned_s),
    .full    (fifo_full_s),
    .rd_en   (rd_s),
    .rd_data (psum_out_flat),
    .empty   (fifo_empty_s),
    .count   (fifo_count)
  );

  // Sticky drop flag and accepted-row counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r     <= 1'b0;
      rows_written_r <= '0;
    end else begin
      overflow_r     <= overflow_r | drop_s;
      rows_written_r <= wr_ok_s ? rows_written_r + CNT_WIDTH'(1) : rows_written_r;
    end
  end

  assign overflow     = overflow_r;
  assign rows_written = rows_written_r;

endmodule
